// File: rtl/bypass_reg_file_pkg.sv
// Shared CPU constants: default register-file geometry and the ID-stage opcodes
// used to decide when a load leaves ID and must mark its destination pending.
package bypass_reg_file_pkg;

    localparam int CPU_WIDTH    = 16;
    localparam int CPU_NUM_REGS = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_SLT = 4'b0100,
        OP_LW  = 4'b0101,
        OP_SW  = 4'b0110,
        OP_BEQ = 4'b0111
    } opcode_e;

    function automatic logic is_load(input opcode_e op);
        return op == OP_LW;
    endfunction

endpackage

// File: rtl/bypass_reg_file_if.sv
// Register-file port bundle: two read ports, the WB write port, the load-issue
// marker from ID and the hazard outputs back to IF/ID.
interface bypass_reg_file_if
    import bypass_reg_file_pkg::*;
#(
    parameter int WIDTH    = CPU_WIDTH,
    parameter int NUM_REGS = CPU_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);
    logic [ADDR_W-1:0]   rr1;
    logic [ADDR_W-1:0]   rr2;
    logic [WIDTH-1:0]    rd1;
    logic [WIDTH-1:0]    rd2;
    logic                regwrite;
    logic [ADDR_W-1:0]   wr;
    logic [WIDTH-1:0]    wd;
    logic                ld_issue;
    logic [ADDR_W-1:0]   ld_dst;
    logic                stall;
    logic [NUM_REGS-1:0] busy;

    modport master (
        output rr1, rr2, regwrite, wr, wd, ld_issue, ld_dst,
        input  rd1, rd2, stall, busy
    );

    modport slave (
        input  rr1, rr2, regwrite, wr, wd, ld_issue, ld_dst,
        output rd1, rd2, stall, busy
    );

endinterface

// File: rtl/bypass_reg_file_reg_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set when a load leaves ID
// and cleared by the writeback to that register. r0 never becomes busy.
module reg_scoreboard #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_issue_i,
    input  logic [ADDR_W-1:0]   ld_dst_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // A load issuing to the register being written back keeps it busy: the new
    // load's data has not arrived yet, so set takes priority over clear.
    always_comb begin
        busy_d = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy_d[i] = (ld_issue_i && (ld_dst_i == ADDR_W'(i)))
                      | (busy_q[i] & ~(wr_en_i && (wr_addr_i == ADDR_W'(i))));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/bypass_reg_file.sv
// Parametrised pipeline register file with optional WB-to-ID bypass and a
// load-use stall derived from the pending-load scoreboard.
module bypass_reg_file
    import bypass_reg_file_pkg::*;
#(
    parameter int WIDTH    = CPU_WIDTH,
    parameter int NUM_REGS = CPU_NUM_REGS,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bypass_reg_file_if.slave  bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                hit1;
    logic                hit2;
    logic                res1;
    logic                res2;
    logic [WIDTH-1:0]    rd1;
    logic [WIDTH-1:0]    rd2;
    logic                stall;

    always_comb begin
        regs_d = regs_q;
        if (bus.regwrite && (bus.wr != '0)) begin
            regs_d[bus.wr] = bus.wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_issue_i (bus.ld_issue),
        .ld_dst_i   (bus.ld_dst),
        .wr_en_i    (bus.regwrite),
        .wr_addr_i  (bus.wr),
        .busy_o     (busy)
    );

    // Outputs are forced quiet while rst_n is low, so a write strobe that is
    // still asserted during reset cannot leak through the bypass path.
    always_comb begin
        hit1  = (BYPASS != 0) && bus.regwrite && (bus.wr == bus.rr1) && (bus.wr != '0);
        hit2  = (BYPASS != 0) && bus.regwrite && (bus.wr == bus.rr2) && (bus.wr != '0);
        res1  = (BYPASS != 0) && bus.regwrite && (bus.wr == bus.rr1);
        res2  = (BYPASS != 0) && bus.regwrite && (bus.wr == bus.rr2);
        rd1   = '0;
        rd2   = '0;
        if (rst_n && (bus.rr1 != '0)) begin
            rd1 = hit1 ? bus.wd : regs_q[bus.rr1];
        end
        if (rst_n && (bus.rr2 != '0)) begin
            rd2 = hit2 ? bus.wd : regs_q[bus.rr2];
        end
        stall = rst_n && ((busy[bus.rr1] && !res1) || (busy[bus.rr2] && !res2));
    end

    assign bus.rd1   = rd1;
    assign bus.rd2   = rd2;
    assign bus.stall = stall;
    assign bus.busy  = busy;

endmodule
